// File: rtl/x_stage_md_pkg.sv
// x_stage_md_pkg: shared types for the execute stage and its iterative mul/div unit.
package x_stage_md_pkg;
   localparam int CORE_N_BITS = 32;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_t;
   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } md_op_t;
   typedef enum logic [1:0] {RES_ALU, RES_PC4, RES_MD} x_res_sel_t;
   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
   typedef struct packed {
      logic       we;
      logic [4:0] rd;
   } rf_ctrl_t;
   function automatic logic signed_a(md_op_t op);
      return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction
   function automatic logic signed_b(md_op_t op);
      return op inside {MD_MULH, MD_DIV, MD_REM};
   endfunction
endpackage

// File: rtl/x_stage_md_if.sv
// x_stage_md_if: D-stage operands/control into X and the X result bundle toward M.
interface x_stage_md_if
   import x_stage_md_pkg::*;
#(
   parameter int N_BITS = CORE_N_BITS
) ();
   logic              valid_in;
   alu_op_t           alu_op_nxt;
   logic              md_en_nxt;
   md_op_t            md_op_nxt;
   x_res_sel_t        res_sel_nxt;
   rf_ctrl_t          rf_ctrl_pkt_in;
   logic [N_BITS-1:0] op1_nxt;
   logic [N_BITS-1:0] op2_nxt;
   logic [N_BITS-1:0] pc_plus4_in;
   logic [N_BITS-1:0] branch_tgt_in;
   logic              flush;
   logic              stall_in;
   logic              valid_out;
   rf_ctrl_t          rf_ctrl_pkt_out;
   logic [N_BITS-1:0] branch_tgt;
   logic [N_BITS-1:0] data_out;
   logic              stall;
   modport master (
      output valid_in, alu_op_nxt, md_en_nxt, md_op_nxt, res_sel_nxt, rf_ctrl_pkt_in,
             op1_nxt, op2_nxt, pc_plus4_in, branch_tgt_in, flush, stall_in,
      input  valid_out, rf_ctrl_pkt_out, branch_tgt, data_out, stall
   );
   modport slave (
      input  valid_in, alu_op_nxt, md_en_nxt, md_op_nxt, res_sel_nxt, rf_ctrl_pkt_in,
             op1_nxt, op2_nxt, pc_plus4_in, branch_tgt_in, flush, stall_in,
      output valid_out, rf_ctrl_pkt_out, branch_tgt, data_out, stall
   );
endinterface

// File: rtl/alu.sv
// alu: single-cycle integer ALU for the execute stage.
module alu
   import x_stage_md_pkg::*;
#(
   parameter int N_BITS = CORE_N_BITS
) (
   input  alu_op_t           op,
   input  logic [N_BITS-1:0] a,
   input  logic [N_BITS-1:0] b,
   output logic [N_BITS-1:0] y
);
   localparam int SW = $clog2(N_BITS);
   logic [SW-1:0] sh;
   assign sh = b[SW-1:0];
   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLL:  y = a << sh;
         ALU_SRL:  y = a >> sh;
         ALU_SRA:  y = $signed(a) >>> sh;
         ALU_SLT:  y = {{(N_BITS-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: y = {{(N_BITS-1){1'b0}}, a < b};
         default:  y = '0;
      endcase
   end
endmodule

// File: rtl/dl_reg_en_rst.sv
// dl_reg_en_rst: enabled pipeline register with asynchronous active-low clear.
module dl_reg_en_rst #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/x_stage_md_muldiv.sv
// x_muldiv_iter: radix-2 iterative multiply / restoring divide on operand magnitudes,
// with a sign fixup folded into the final iteration.
module x_muldiv_iter
   import x_stage_md_pkg::*;
#(
   parameter int N_BITS = CORE_N_BITS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              kill,
   input  logic              advance,
   input  md_op_t            op,
   input  logic [N_BITS-1:0] a,
   input  logic [N_BITS-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [N_BITS-1:0] result
);
   localparam int CW = $clog2(N_BITS);
   md_state_t state, state_nxt;
   md_op_t op_q;
   logic [CW-1:0] count;
   logic [2*N_BITS-1:0] acc, acc_step, prod;
   logic [N_BITS-1:0] m, a_q, mag_a, mag_b, q_fix, r_fix, fix_res;
   logic [N_BITS:0] sum, rem_sh, diff;
   logic sa, sb, neg_q, neg_r, dz, last, load;
   assign sa = a[N_BITS-1] & signed_a(op);
   assign sb = b[N_BITS-1] & signed_b(op);
   assign mag_a = sa ? -a : a;
   assign mag_b = sb ? -b : b;
   assign last = count == CW'(N_BITS - 1);
   assign load = state == MD_IDLE && start && !kill;
   assign busy = state == MD_BUSY;
   assign done = state == MD_DONE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= MD_IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = kill ? MD_IDLE :
                  (state == MD_IDLE && start)   ? MD_BUSY :
                  (state == MD_BUSY && last)    ? MD_DONE :
                  (state == MD_DONE && advance) ? MD_IDLE : state;
   end
   // acc is {hi, lo} of the product while multiplying, {remainder, quotient} while dividing
   assign sum = {1'b0, acc[2*N_BITS-1:N_BITS]} + (acc[0] ? {1'b0, m} : '0);
   assign rem_sh = acc[2*N_BITS-1:N_BITS-1];
   assign diff = rem_sh - {1'b0, m};
   assign acc_step = !op_q[2]       ? {sum, acc[N_BITS-1:1]} :
                     diff[N_BITS]   ? {rem_sh[N_BITS-1:0], acc[N_BITS-2:0], 1'b0} :
                                      {diff[N_BITS-1:0], acc[N_BITS-2:0], 1'b1};
   assign prod = neg_q ? -acc_step : acc_step;
   assign q_fix = neg_q ? -acc_step[N_BITS-1:0] : acc_step[N_BITS-1:0];
   assign r_fix = neg_r ? -acc_step[2*N_BITS-1:N_BITS] : acc_step[2*N_BITS-1:N_BITS];
   // divide by zero bypasses the sign fixup; signed overflow falls out of the magnitudes
   assign fix_res = !op_q[2] ? (op_q == MD_MUL ? prod[N_BITS-1:0] : prod[2*N_BITS-1:N_BITS]) :
                    op_q[1]  ? (dz ? a_q : r_fix) : (dz ? '1 : q_fix);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op_q <= MD_MUL;
         {count, acc, m, a_q, neg_q, neg_r, dz, result} <= '0;
      end else if (load) begin
         op_q  <= op;
         count <= '0;
         acc   <= {{N_BITS{1'b0}}, op[2] ? mag_a : mag_b};
         m     <= op[2] ? mag_b : mag_a;
         a_q   <= a;
         neg_q <= sa ^ sb;
         neg_r <= sa;
         dz    <= b == '0;
      end else if (busy && !kill) begin
         acc   <= acc_step;
         count <= count + 1'b1;
         if (last) result <= fix_res;
      end
endmodule

// File: rtl/x_stage_md.sv
// x_stage_md: execute stage registering D-stage operands, with single-cycle ALU results
// and an iterative mul/div that holds the pipe through a local stall.
module x_stage_md
   import x_stage_md_pkg::*;
#(
   parameter int N_BITS = CORE_N_BITS,
   parameter bit MD_EN  = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   x_stage_md_if.slave x
);
   localparam int RW = 4*N_BITS + $bits(alu_op_t) + 1 + $bits(md_op_t) + $bits(x_res_sel_t) + $bits(rf_ctrl_t);
   logic [RW-1:0] d, q;
   logic en, valid, md_en, md_req, local_stall;
   logic [N_BITS-1:0] op1, op2, pc_plus4, alu_out, md_result;
   logic [$bits(alu_op_t)-1:0] alu_op;
   logic [$bits(md_op_t)-1:0] md_op;
   logic [$bits(x_res_sel_t)-1:0] res_sel;
   assign en = ~x.stall;
   assign d = {x.op1_nxt, x.op2_nxt, x.pc_plus4_in, x.branch_tgt_in, x.alu_op_nxt,
               x.md_en_nxt, x.md_op_nxt, x.res_sel_nxt, x.rf_ctrl_pkt_in};
   assign {op1, op2, pc_plus4, x.branch_tgt, alu_op, md_en, md_op, res_sel, x.rf_ctrl_pkt_out} = q;
   dl_reg_en_rst #(.W(RW)) u_regs (.clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(q));
   // flush clears valid even while the stage is stalled
   dl_reg_en_rst #(.W(1)) u_valid (
      .clk(clk), .rst_n(rst_n), .en(en | x.flush), .d(x.valid_in & ~x.flush), .q(valid)
   );
   alu #(.N_BITS(N_BITS)) u_alu (.op(alu_op_t'(alu_op)), .a(op1), .b(op2), .y(alu_out));
   assign md_req = valid & md_en;
   if (MD_EN) begin : g_md
      logic md_busy, md_done;
      x_muldiv_iter #(.N_BITS(N_BITS)) u_md (
         .clk(clk), .rst_n(rst_n), .start(md_req), .kill(x.flush), .advance(~x.stall_in),
         .op(md_op_t'(md_op)), .a(op1), .b(op2), .busy(md_busy), .done(md_done), .result(md_result)
      );
      assign local_stall = md_busy | (md_req & ~md_done);
   end else begin : g_no_md
      assign md_result = '0;
      assign local_stall = 1'b0;
   end
   assign x.valid_out = valid;
   assign x.stall = x.stall_in | local_stall;
   assign x.data_out = res_sel == RES_PC4 ? pc_plus4 : res_sel == RES_MD ? md_result : alu_out;
endmodule

// File: tb/tb_x_stage_md.sv
// tb_x_stage_md: directed and randomized checks of x_stage_md against a behavioural model.
module tb_x_stage_md;
   import x_stage_md_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   x_stage_md_if #(.N_BITS(32)) xi ();
   x_stage_md #(.N_BITS(32), .MD_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .x(xi));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
      int sa = a;
      int sb = b;
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return sa >>> b[4:0];
         ALU_SLT:  return sa < sb ? 1 : 0;
         ALU_SLTU: return a < b ? 1 : 0;
         default:  return 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_md(md_op_t op, logic [31:0] a, logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = a;
      longint ub = b;
      longint unsigned p;
      logic ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
      case (op)
         MD_MUL:    return 32'(sa * sb);
         MD_MULH:   return 32'((sa * sb) >>> 32);
         MD_MULHSU: return 32'((sa * ub) >>> 32);
         MD_MULHU:  begin p = ua * ub; return 32'(p >> 32); end
         MD_DIV:    return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         MD_DIVU:   return b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
         MD_REM:    return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
         default:   return b == 0 ? a : 32'(ua % ub);
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // issue one instruction, wait out any stall, check the result, optionally hold it with stall_in
   task automatic run(input string tag, input x_res_sel_t sel, input alu_op_t aop, input md_op_t mop,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc4,
                      input logic [31:0] btgt, input int hold);
      logic [31:0] exp;
      rf_ctrl_t rf;
      int n;
      exp = sel == RES_PC4 ? pc4 : sel == RES_MD ? ref_md(mop, a, b) : ref_alu(aop, a, b);
      rf = 6'($urandom_range(0, 63));
      xi.valid_in = 1'b1;
      xi.alu_op_nxt = aop;
      xi.md_en_nxt = sel == RES_MD;
      xi.md_op_nxt = mop;
      xi.res_sel_nxt = sel;
      xi.rf_ctrl_pkt_in = rf;
      xi.op1_nxt = a;
      xi.op2_nxt = b;
      xi.pc_plus4_in = pc4;
      xi.branch_tgt_in = btgt;
      @(posedge clk); #1;
      xi.valid_in = 1'b0;
      check({tag, ".btgt"}, xi.branch_tgt, btgt);
      n = 0;
      while (xi.stall && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      check({tag, ".lat"}, n, sel == RES_MD ? 33 : 0);
      check({tag, ".data"}, xi.data_out, exp);
      check({tag, ".valid"}, xi.valid_out, 1);
      check({tag, ".rf"}, xi.rf_ctrl_pkt_out, rf);
      if (hold > 0) begin
         xi.stall_in = 1'b1;
         for (int i = 0; i < hold; i++) begin
            #1;
            check({tag, ".hold_data"}, xi.data_out, exp);
            check({tag, ".hold_stall"}, xi.stall, 1);
            @(posedge clk); #1;
         end
         xi.stall_in = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      x_res_sel_t sel;
      xi.valid_in = 1'b0;
      xi.alu_op_nxt = ALU_ADD;
      xi.md_en_nxt = 1'b0;
      xi.md_op_nxt = MD_MUL;
      xi.res_sel_nxt = RES_ALU;
      xi.rf_ctrl_pkt_in = '0;
      xi.op1_nxt = '0;
      xi.op2_nxt = '0;
      xi.pc_plus4_in = '0;
      xi.branch_tgt_in = '0;
      xi.flush = 1'b0;
      xi.stall_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.valid", xi.valid_out, 0);
      check("rst.stall", xi.stall, 0);
      check("rst.data", xi.data_out, 0);
      check("rst.btgt", xi.branch_tgt, 0);
      check("rst.rf", xi.rf_ctrl_pkt_out, 0);
      rst_n = 1'b1;
      run("add", RES_ALU, ALU_ADD, MD_MUL, 5, 7, 0, 0, 0);
      run("pc4", RES_PC4, ALU_ADD, MD_MUL, 1, 2, 32'h104, 32'h200, 0);
      run("mul", RES_MD, ALU_ADD, MD_MUL, 7, 32'hFFFF_FFFD, 0, 0, 0);
      run("mulhu", RES_MD, ALU_ADD, MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
      run("div0", RES_MD, ALU_ADD, MD_DIV, 100, 0, 0, 0, 0);
      run("rem0", RES_MD, ALU_ADD, MD_REM, 100, 0, 0, 0, 0);
      run("divovf", RES_MD, ALU_ADD, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      run("removf", RES_MD, ALU_ADD, MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      run("remneg", RES_MD, ALU_ADD, MD_REM, 32'hFFFF_FFF9, 2, 0, 0, 0);
      run("divu_hold", RES_MD, ALU_ADD, MD_DIVU, 100, 7, 0, 0, 5);
      run("after_hold", RES_ALU, ALU_SUB, MD_MUL, 20, 8, 0, 32'h44, 0);
      // flush a divide partway through its iterations
      xi.valid_in = 1'b1;
      xi.md_en_nxt = 1'b1;
      xi.md_op_nxt = MD_DIVU;
      xi.res_sel_nxt = RES_MD;
      xi.op1_nxt = 50;
      xi.op2_nxt = 5;
      @(posedge clk); #1;
      xi.valid_in = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("flush.busy_stall", xi.stall, 1);
      xi.flush = 1'b1;
      @(posedge clk); #1;
      xi.flush = 1'b0;
      check("flush.valid", xi.valid_out, 0);
      check("flush.stall", xi.stall, 0);
      run("after_flush", RES_MD, ALU_ADD, MD_DIVU, 9, 3, 0, 0, 0);
      // asynchronous reset in the middle of a multiply
      xi.valid_in = 1'b1;
      xi.md_en_nxt = 1'b1;
      xi.md_op_nxt = MD_MUL;
      xi.res_sel_nxt = RES_MD;
      @(posedge clk); #1;
      xi.valid_in = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst.stall", xi.stall, 0);
      check("arst.valid", xi.valid_out, 0);
      check("arst.data", xi.data_out, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run("after_arst", RES_MD, ALU_ADD, MD_MULH, 32'hFFFF_FFFE, 3, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 3) < 2 ? RES_MD : ($urandom_range(0, 1) ? RES_PC4 : RES_ALU);
         run($sformatf("rnd%0d", i), sel, alu_op_t'($urandom_range(0, 9)), md_op_t'($urandom_range(0, 7)),
             pick(), pick(), $urandom, $urandom, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
